finv: RTL and testbench



---
 rtl/fpu_pkg.sv | 38 +++
 rtl/finv_seed_rom.sv | 27 ++
 rtl/finv.sv | 157 +++++++++++++++
 tb/tb_finv.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// ============================================================================
//  Module   : fpu_pkg
//  Brief    : Shared float field widths, constants, finv state encoding and
//             the reciprocal seed-table generator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  localparam int         SIGN_W   = 1;
  localparam int         EXP_W    = 8;
  localparam int         MANT_W   = 23;
  localparam int         EXP_BIAS = 127;
  localparam logic [7:0] EXP_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEED = 3'd1,
    ST_IT_A = 3'd2,
    ST_IT_B = 3'd3,
    ST_NORM = 3'd4,
    ST_DONE = 3'd5
  } finv_state_t;

  // round(2^(seed_w-1) / (1 + (idx+0.5)/256)) evaluated in integers
  function automatic int unsigned seed_entry(input int unsigned idx,
                                             input int unsigned seed_w);
    longint unsigned num;
    longint unsigned den;
    den = 64'd512 + 64'(2 * idx) + 64'd1;
    num = (64'd1 << seed_w) * 64'd512;
    return int'((num + den) / (64'd2 * den));
  endfunction

endpackage

`default_nettype wire

// File: rtl/finv_seed_rom.sv
// ============================================================================
//  Module   : finv_seed_rom
//  Brief    : 256-entry reciprocal seed table, Q1.(SEED_W-1), indexed by the
//             top eight mantissa bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module finv_seed_rom #(
  parameter int SEED_W = 12
) (
  input  logic [7:0]        i_idx,
  output logic [SEED_W-1:0] o_seed
);
  import fpu_pkg::*;

  logic [SEED_W-1:0] w_rom [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    assign w_rom[gi] = SEED_W'(seed_entry(gi, SEED_W));
  end

  assign o_seed = w_rom[i_idx];

endmodule

`default_nettype wire

// File: rtl/finv.sv
// ============================================================================
//  Module   : finv
//  Brief    : Iterative Newton-Raphson single-precision reciprocal with one
//             shared multiplier. Optional macro FINV_EARLY_OUT_EN skips the
//             iterations for m==0, zero and inf/NaN operands.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module finv #(
  parameter int NR_ITER = 2,   // legal range 1..3
  parameter int SEED_W  = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        ready,
  output logic [31:0] y,
  output logic        valid
);
  import fpu_pkg::*;

  // Internal fixed point is Q2.30: bit 30 weighs 1.0
  localparam int FW = 30;
  localparam int YW = 32;

  finv_state_t r_state;
  finv_state_t w_state_nxt;

  logic [SIGN_W-1:0] r_sign;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant;
  logic [YW-1:0]     r_yi;
  logic [YW-1:0]     r_t;
  logic [1:0]        r_iter;
  logic [31:0]       r_y;

  logic [SEED_W-1:0] w_seed;
  logic [YW-1:0]     w_d;
  logic [YW-1:0]     w_mul_a;
  logic [YW-1:0]     w_mul_b;
  logic [2*YW-1:0]   w_prod;
  logic [YW-1:0]     w_prod_q;
  logic              w_early;
  logic [23:0]       w_rnd;
  logic              w_carry;
  logic [9:0]        w_exp_res;
  logic [22:0]       w_frac;
  logic [31:0]       w_result;

  finv_seed_rom #(
    .SEED_W (SEED_W)
  ) u_seed_rom (
    .i_idx  (r_mant[22:15]),
    .o_seed (w_seed)
  );

`ifdef FINV_EARLY_OUT_EN
  assign w_early = (r_mant == '0) || (r_exp == '0) || (r_exp == EXP_MAX);
`else
  assign w_early = 1'b0;
`endif

  assign w_d = {1'b0, 1'b1, r_mant, 7'd0};

  always_comb begin
    w_mul_a = w_d;
    w_mul_b = r_yi;
    if (r_state == ST_IT_B) begin
      w_mul_a = r_yi;
      w_mul_b = 32'h8000_0000 - r_t;
    end
  end

  assign w_prod   = w_mul_a * w_mul_b;
  assign w_prod_q = YW'(w_prod >> FW);

  // Doubling y brings it into [1,2); round at bit 5 of the Q2.30 value
  assign w_rnd   = {1'b0, r_yi[28:6]} + 24'(r_yi[5]);
  assign w_carry = w_rnd[23];

  always_comb begin
    w_exp_res = 10'(2 * EXP_BIAS - 1) - {2'b00, r_exp};
    w_frac    = '0;
    if (r_mant == '0) begin
      w_exp_res = 10'(2 * EXP_BIAS) - {2'b00, r_exp};
    end else if (r_yi[29]) begin
      w_exp_res = w_exp_res + {9'd0, w_carry};
      w_frac    = w_carry ? 23'd0 : w_rnd[22:0];
    end
    // y at or below 0.5 only happens for d just under 2: result rounds to 1.0

    if (r_exp == '0) begin
      w_result = {r_sign, EXP_MAX, 23'd0};
    end else if (r_exp == EXP_MAX) begin
      w_result = {r_sign, 31'd0};
    end else if (w_exp_res[9] || (w_exp_res == '0)) begin
      w_result = {r_sign, 31'd0};
    end else begin
      w_result = {r_sign, w_exp_res[7:0], w_frac};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (ready) w_state_nxt = ST_SEED;
      ST_SEED: w_state_nxt = w_early ? ST_NORM : ST_IT_A;
      ST_IT_A: w_state_nxt = ST_IT_B;
      ST_IT_B: w_state_nxt = (r_iter == 2'(NR_ITER - 1)) ? ST_NORM : ST_IT_A;
      ST_NORM: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_sign  <= '0;
      r_exp   <= '0;
      r_mant  <= '0;
      r_yi    <= '0;
      r_t     <= '0;
      r_iter  <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (ready) begin
            r_sign <= x[31];
            r_exp  <= x[30:23];
            r_mant <= x[22:0];
          end
        end
        ST_SEED: begin
          r_yi   <= YW'(w_seed) << (FW - SEED_W + 1);
          r_iter <= '0;
        end
        ST_IT_A: r_t <= w_prod_q;
        ST_IT_B: begin
          r_yi   <= w_prod_q;
          r_iter <= r_iter + 2'd1;
        end
        ST_NORM: r_y <= w_result;
        default: ;
      endcase
    end
  end

  assign y     = r_y;
  assign valid = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_finv.sv
// ============================================================================
//  Module   : tb_finv
//  Brief    : Self-checking bench for finv against a real-arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_finv;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  finv dut (
    .clk   (clk),
    .rstn  (rstn),
    .x     (x),
    .ready (ready),
    .y     (y),
    .valid (valid)
  );

  // Correctly rounded reciprocal from the float rules, using real arithmetic
  function automatic logic [31:0] ref_recip(input logic [31:0] xv);
    logic s;
    int   e;
    int   m;
    int   ee;
    int   q;
    real  r;
    s = xv[31];
    e = int'(xv[30:23]);
    m = int'(xv[22:0]);
    if (e == 0)   return {s, 8'hFF, 23'd0};
    if (e == 255) return {s, 31'd0};
    if (m == 0) begin
      ee = 254 - e;
      q  = 0;
    end else begin
      r  = 2.0 / (1.0 + real'(m) / 8388608.0);
      q  = $rtoi((r - 1.0) * 8388608.0 + 0.5);
      ee = 253 - e;
      if (q >= 8388608) begin
        q  = 0;
        ee = ee + 1;
      end
    end
    if (ee <= 0) return {s, 31'd0};
    return {s, 8'(ee), 23'(q)};
  endfunction

  function automatic int exp_lat(input logic [31:0] xv);
`ifdef FINV_EARLY_OUT_EN
    if (xv[22:0] == 23'd0 || xv[30:23] == 8'd0 || xv[30:23] == 8'hFF) return 3;
`endif
    return 7;
  endfunction

  function automatic logic [31:0] rand_normal();
    return {1'($urandom), 8'($urandom_range(252, 1)), 23'($urandom)};
  endfunction

  // One operation; lat = cycle of the first valid (cycle 1 = SEED), 0 if none
  task automatic run_op(input logic [31:0] xv, output logic [31:0] yv,
                        output int lat, output int nval);
    @(negedge clk);
    x     = xv;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    x     = $urandom;
    lat   = 0;
    nval  = 0;
    yv    = 'x;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        nval++;
        if (lat == 0) begin
          lat = k;
          yv  = y;
        end
      end
    end
  endtask

  task automatic test_reset;
    rstn  = 1'b0;
    ready = 1'b0;
    x     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 0", valid);
    end
    checks++;
    if (y !== 32'h0) begin
      failures++;
      $display("FAIL reset_y: got %h expected 00000000", y);
    end
    rstn = 1'b1;
  endtask

  task automatic test_pow2;
    logic [31:0] yv;
    int lat, nval;
    run_op(32'h40000000, yv, lat, nval);
    checks++;
    if (yv !== 32'h3F000000) begin
      failures++;
      $display("FAIL pow2_y: got %h expected 3f000000", yv);
    end
    checks++;
    if (lat != exp_lat(32'h40000000)) begin
      failures++;
      $display("FAIL pow2_latency: got %0d expected %0d", lat, exp_lat(32'h40000000));
    end
    checks++;
    if (nval != 1) begin
      failures++;
      $display("FAIL pow2_valid_count: got %0d expected 1", nval);
    end
  endtask

  task automatic test_nontrivial;
    logic [31:0] xs [2];
    logic [31:0] es [2];
    logic [31:0] yv;
    logic [31:0] d;
    int lat, nval;
    xs[0] = 32'hC0400000; es[0] = 32'hBEAAAAAB;
    xs[1] = 32'h3FC00000; es[1] = 32'h3F2AAAAB;
    for (int i = 0; i < 2; i++) begin
      run_op(xs[i], yv, lat, nval);
      d = yv - es[i];
      checks++;
      if (!(d === 32'd0 || d === 32'd1 || d === 32'hFFFFFFFF)) begin
        failures++;
        $display("FAIL nontrivial_y x=%h: got %h expected %h +-1ulp", xs[i], yv, es[i]);
      end
      checks++;
      if (lat != 7 || nval != 1) begin
        failures++;
        $display("FAIL nontrivial_latency x=%h: got lat=%0d n=%0d expected lat=7 n=1", xs[i], lat, nval);
      end
    end
  endtask

  // Exact-result cases: zero, inf, and the exponent flush boundary
  task automatic test_specials;
    logic [31:0] xs [6];
    logic [31:0] es [6];
    logic [31:0] yv;
    int lat, nval;
    xs[0] = 32'h00000000; es[0] = 32'h7F800000;
    xs[1] = 32'h80000000; es[1] = 32'hFF800000;
    xs[2] = 32'h7F800000; es[2] = 32'h00000000;
    xs[3] = 32'h7E800000; es[3] = 32'h00800000;
    xs[4] = 32'h7F000000; es[4] = 32'h00000000;
    xs[5] = 32'h7E800001; es[5] = 32'h00000000;
    for (int i = 0; i < 6; i++) begin
      run_op(xs[i], yv, lat, nval);
      checks++;
      if (yv !== es[i]) begin
        failures++;
        $display("FAIL special_y x=%h: got %h expected %h", xs[i], yv, es[i]);
      end
      checks++;
      if (lat != exp_lat(xs[i]) || nval != 1) begin
        failures++;
        $display("FAIL special_latency x=%h: got lat=%0d n=%0d expected lat=%0d n=1",
                 xs[i], lat, nval, exp_lat(xs[i]));
      end
    end
  endtask

  // ready held high, x new every cycle: accepts every 8 edges from edge 0
  task automatic test_back_to_back;
    logic [31:0] xs [48];
    logic [31:0] d;
    logic        exp_v;
    @(negedge clk);
    for (int n = 0; n < 48; n++) begin
      if (n > 0) begin
        exp_v = (n >= 7) && ((n - 7) % 8 == 0);
        checks++;
        if (valid !== exp_v) begin
          failures++;
          $display("FAIL b2b_valid n=%0d: got %b expected %b", n, valid, exp_v);
        end
        if (exp_v) begin
          d = y - ref_recip(xs[n-7]);
          checks++;
          if (!(d === 32'd0 || d === 32'd1 || d === 32'hFFFFFFFF)) begin
            failures++;
            $display("FAIL b2b_y x=%h: got %h expected %h +-1ulp", xs[n-7], y, ref_recip(xs[n-7]));
          end
        end
      end
      xs[n] = rand_normal() | 32'd1;
      x     = xs[n];
      ready = 1'b1;
      @(negedge clk);
    end
    ready = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat  = 0;
    int nval = 0;
    @(negedge clk);
    x     = 32'h40400000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || y !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_state: got valid=%b y=%h expected valid=0 y=00000000", valid, y);
    end
    rstn  = 1'b1;
    x     = 32'h40000000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        nval++;
        if (lat == 0) lat = k;
      end
    end
    checks++;
    if (lat != exp_lat(32'h40000000) || nval != 1 || y !== 32'h3F000000) begin
      failures++;
      $display("FAIL reset_mid_restart: got lat=%0d n=%0d y=%h expected lat=%0d n=1 y=3f000000",
               lat, nval, y, exp_lat(32'h40000000));
    end
  endtask

  task automatic test_random;
    logic [31:0] xv;
    logic [31:0] yv;
    logic [31:0] er;
    logic [31:0] d;
    int lat, nval;
    for (int i = 0; i < 3000; i++) begin
      xv = rand_normal();
      er = ref_recip(xv);
      run_op(xv, yv, lat, nval);
      d = yv - er;
      checks++;
      if (!(d === 32'd0 || d === 32'd1 || d === 32'hFFFFFFFF)) begin
        failures++;
        $display("FAIL random_y x=%h: got %h expected %h +-1ulp", xv, yv, er);
      end
      checks++;
      if (lat != exp_lat(xv) || nval != 1) begin
        failures++;
        $display("FAIL random_latency x=%h: got lat=%0d n=%0d expected lat=%0d n=1",
                 xv, lat, nval, exp_lat(xv));
      end
    end
  endtask

  initial begin
    rstn  = 1'b0;
    ready = 1'b0;
    x     = '0;
    test_reset();
    test_pow2();
    test_nontrivial();
    test_specials();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
